pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 1, range 0..7: extra cycles IDU_flush stays asserted after a redirect.
REQ-002 SHALL have parameter CNT_W, default 32: stall-counter width.
REQ-003 SHALL have port clk, in, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have port IDU_rs1_choice, in, 2: forward code; 00 none, 01 EXU, 10 MEM ALU, 11 MEM load.
REQ-006 SHALL have port IDU_rs2_choice, in, 2: same encoding as IDU_rs1_choice.
REQ-007 SHALL have ports IDU_rs1_used and IDU_rs2_used, in, 1 each: the ID instruction reads that source.
REQ-008 SHALL have port IDU_valid, in, 1: the ID stage holds a valid instruction.
REQ-009 SHALL have port EXU_mem_ren, in, 1: the EXU instruction is a load.
REQ-010 SHALL have port EXU_redirect, in, 1: taken branch/jump resolved in EXU; held by EXU while EXU is stalled.
REQ-011 SHALL have ports MEM_req_valid and MEM_req_ready, in, 1 each: data-memory request handshake.
REQ-012 SHALL have outputs IFU_stall, IDU_stall, EXU_stall, MEM_stall, EXU_bubble, IFU_flush and IDU_flush, out, 1 each.
REQ-013 SHALL have output stall_cnt, out, CNT_W: count of lost cycles.

Function
REQ-014 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT and FLUSH; all outputs combinational from state and inputs (Mealy).
REQ-015 SHALL define mem_wait = MEM_req_valid && !MEM_req_ready.
REQ-016 SHALL define load_use = IDU_valid && EXU_mem_ren && ((IDU_rs1_used && IDU_rs1_choice==01) || (IDU_rs2_used && IDU_rs2_choice==01)).
REQ-017 SHALL apply priority mem_wait > EXU_redirect > load_use > FLUSH-state hold.
REQ-018 On mem_wait, any state: IFU_stall, IDU_stall, EXU_stall, MEM_stall=1; no flush or bubble; next state MEM_WAIT; any FLUSH cycle count is frozen.
REQ-019 On MEM_WAIT exit (mem_wait=0): normal evaluation resumes that cycle; the held EXU_redirect is acted on then.
REQ-020 On EXU_redirect without mem_wait: IFU_flush=1, IDU_flush=1 and EXU_bubble=1 in the same cycle.
REQ-021 After a redirect: if FLUSH_CYC>0, next state FLUSH with the counter loaded to FLUSH_CYC; else next state RUN.
REQ-022 In FLUSH: IDU_flush=1 each cycle; counter decrements; return to RUN after FLUSH_CYC cycles; a new redirect reloads the counter.
REQ-023 On load_use in RUN without a higher-priority event: IFU_stall=1, IDU_stall=1, EXU_bubble=1 for exactly one cycle; next state LU_STALL.
REQ-024 In LU_STALL: load_use is masked, so there is at most one bubble per load; return to RUN next cycle unless a higher-priority event occurs.
REQ-025 Choice code 11 (MEM load) SHALL never stall; forwarding covers it.
REQ-026 SHALL increment stall_cnt by 1 in each cycle where IDU_stall or IDU_flush is 1; stall_cnt saturates at all-ones with no wrap.
REQ-027 SHALL ignore load_use when IDU_valid=0.

Reset
REQ-028 While rst=1: state=RUN, FLUSH counter=0, stall_cnt=0, every stall/flush/bubble output=0, asynchronously.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abort that stall/flush immediately; no pending redirect is retained.
REQ-030 First clk edge after rst falls SHALL evaluate from RUN.

Structure
REQ-031 Shared package SHALL hold the FSM state enum and forward-code constants FWD_NONE, FWD_EXU, FWD_MEM_ALU and FWD_MEM_LD, imported by the forwarding unit as well.
REQ-032 SHALL instantiate one sub-module, sat_counter (parameter width, inc input, synchronous clear via reset), for stall_cnt.
REQ-033 Target size: 120-400 lines of RTL.

Verification
REQ-034 Load-use: EXU_mem_ren=1, IDU_rs1_choice=01, rs1_used=1, IDU_valid=1 in RUN -> IFU/IDU_stall=1 and EXU_bubble=1 for exactly 1 cycle; stall_cnt=1.
REQ-035 Mem wait: MEM_req_valid=1, MEM_req_ready=0 for 3 cycles, simultaneous with a redirect -> all four stalls=1 for 3 cycles and no flush; flush occurs in cycle 4.
REQ-036 Redirect with FLUSH_CYC=2 -> IFU_flush=1 for 1 cycle; IDU_flush=1 for 3 cycles; state back to RUN; stall_cnt=3.
REQ-037 Simultaneous redirect and load_use -> flush only, EXU_bubble=1, no IDU_stall.
REQ-038 Saturation: CNT_W=4 with 20 consecutive stall cycles -> stall_cnt=15.
REQ-039 Reset pulse in the 2nd FLUSH cycle -> all outputs 0 immediately; state RUN after release.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the forwarding unit.
// Holds the FSM state encoding and the forward-source codes.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [1:0] FWD_NONE    = 2'b00;
  localparam logic [1:0] FWD_EXU     = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  // A source needs the EXU result only when it is read and forwarded from EXU.
  function automatic logic needs_exu(input logic used, input logic [1:0] choice);
    return used && (choice == FWD_EXU);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register with async reset and synchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait stalls and redirect flushes.
// Outputs are Mealy (state + inputs); stall_cnt counts cycles lost in ID.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       IDU_rs1_choice,
  input  logic [1:0]       IDU_rs2_choice,
  input  logic             IDU_rs1_used,
  input  logic             IDU_rs2_used,
  input  logic             IDU_valid,
  input  logic             EXU_mem_ren,
  input  logic             EXU_redirect,
  input  logic             MEM_req_valid,
  input  logic             MEM_req_ready,
  output logic             IFU_stall,
  output logic             IDU_stall,
  output logic             EXU_stall,
  output logic             MEM_stall,
  output logic             EXU_bubble,
  output logic             IFU_flush,
  output logic             IDU_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC);

  state_e     state_r, state_s;
  logic [2:0] flush_cnt_r, flush_cnt_s;
  logic       mem_wait_s, load_use_s, load_use_act_s, flush_hold_s;

  assign mem_wait_s = MEM_req_valid && !MEM_req_ready;
  assign load_use_s = IDU_valid && EXU_mem_ren &&
                      (needs_exu(IDU_rs1_used, IDU_rs1_choice) ||
                       needs_exu(IDU_rs2_used, IDU_rs2_choice));
  // One bubble per load: the cycle after a load-use stall ignores the hazard.
  assign load_use_act_s = load_use_s && (state_r != LU_STALL);
  // A nonzero count survives memory waits, so flushing resumes where it left off.
  assign flush_hold_s   = (flush_cnt_r != 3'd0);

  // State and flush-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      flush_cnt_r <= 3'd0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Next-state logic in priority order.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    if (mem_wait_s) begin
      state_s = MEM_WAIT;
    end else if (EXU_redirect) begin
      flush_cnt_s = FLUSH_LD;
      state_s     = (FLUSH_LD != 3'd0) ? FLUSH : RUN;
    end else if (load_use_act_s) begin
      state_s = LU_STALL;
    end else if (flush_hold_s) begin
      flush_cnt_s = flush_cnt_r - 3'd1;
      state_s     = (flush_cnt_r == 3'd1) ? RUN : FLUSH;
    end else begin
      state_s = RUN;
    end
  end

  // Output decode; reset forces everything low regardless of inputs.
  always_comb begin
    IFU_stall  = 1'b0;
    IDU_stall  = 1'b0;
    EXU_stall  = 1'b0;
    MEM_stall  = 1'b0;
    EXU_bubble = 1'b0;
    IFU_flush  = 1'b0;
    IDU_flush  = 1'b0;
    if (rst) begin
      IFU_stall = 1'b0;
    end else if (mem_wait_s) begin
      IFU_stall = 1'b1;
      IDU_stall = 1'b1;
      EXU_stall = 1'b1;
      MEM_stall = 1'b1;
    end else if (EXU_redirect) begin
      IFU_flush  = 1'b1;
      IDU_flush  = 1'b1;
      EXU_bubble = 1'b1;
    end else if (load_use_act_s) begin
      IFU_stall  = 1'b1;
      IDU_stall  = 1'b1;
      EXU_bubble = 1'b1;
    end else if (flush_hold_s) begin
      IDU_flush = 1'b1;
    end else begin
      IDU_flush = 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (IDU_stall || IDU_flush),
    .count (stall_cnt)
  );

endmodule
